// File: rtl/eth_tx_arbiter_if.sv
// Transmit-side bundle linking the ARP and UDP engines, the GMII arbiter and the PHY pins.
// slave = arbiter view, master = engines/PHY view.
interface eth_tx_arbiter_if;
    logic       i_arp_tx_req;
    logic       o_arp_tx_valid;
    logic       i_arp_gmii_tx_en;
    logic [7:0] i_arp_gmii_tx_data;
    logic       i_udp_tx_req;
    logic       o_udp_tx_valid;
    logic       i_udp_gmii_tx_en;
    logic [7:0] i_udp_gmii_tx_data;
    logic       o_gmii_tx_en;
    logic [7:0] o_gmii_tx_data;
    logic       o_err_timeout;
    logic       o_err_spurious;

    modport slave (
        input  i_arp_tx_req, i_arp_gmii_tx_en, i_arp_gmii_tx_data,
        input  i_udp_tx_req, i_udp_gmii_tx_en, i_udp_gmii_tx_data,
        output o_arp_tx_valid, o_udp_tx_valid,
        output o_gmii_tx_en, o_gmii_tx_data, o_err_timeout, o_err_spurious
    );

    modport master (
        output i_arp_tx_req, i_arp_gmii_tx_en, i_arp_gmii_tx_data,
        output i_udp_tx_req, i_udp_gmii_tx_en, i_udp_gmii_tx_data,
        input  o_arp_tx_valid, o_udp_tx_valid,
        input  o_gmii_tx_en, o_gmii_tx_data, o_err_timeout, o_err_spurious
    );
endinterface

// File: rtl/eth_tx_arbiter.sv
// Shares one GMII transmit path between ARP and UDP engines; enforces IFG, start timeout and frame-length cap.
// Data is registered (1-cycle lag); requests wait while busy, a running frame cannot be stalled, only cut.
module eth_tx_arbiter #(
    parameter int IFG_CYCLES    = 12,
    parameter int START_TIMEOUT = 1024,
    parameter int MAX_FRAME     = 1600
) (
    input  logic            i_gmii_tx_clk,
    input  logic            i_rst_n,
    eth_tx_arbiter_if.slave tx
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_START, S_SEND, S_GAP} state_t;

    // The IDLE arbitration cycle and the grantee's first WAIT_START cycle also keep the wire idle,
    // so the GAP state only covers the remainder of IFG_CYCLES.
    localparam bit          LP_USE_GAP     = (IFG_CYCLES > 2);
    localparam logic [15:0] LP_GAP_LAST    = LP_USE_GAP ? 16'(IFG_CYCLES - 3) : 16'd0;
    localparam logic [15:0] LP_START_LAST  = 16'(START_TIMEOUT - 1);
    localparam logic [15:0] LP_MAX_FRAME   = 16'(MAX_FRAME);
    localparam state_t      LP_AFTER_FRAME = LP_USE_GAP ? S_GAP : S_IDLE;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic        r_grant_arp;
    logic        r_grant_udp;
    logic        r_last_arp;
    logic        r_tx_en;
    logic [7:0]  r_tx_data;
    logic        r_err_timeout;
    logic        r_err_spurious;

    logic        w_lane_en;
    logic [7:0]  w_lane_data;
    logic [15:0] w_cnt_inc;
    logic        w_pick_arp;
    logic        w_spurious;

    assign w_lane_en   = (r_grant_arp & tx.i_arp_gmii_tx_en) | (r_grant_udp & tx.i_udp_gmii_tx_en);
    assign w_lane_data = ({8{r_grant_arp}} & tx.i_arp_gmii_tx_data)
                       | ({8{r_grant_udp}} & tx.i_udp_gmii_tx_data);
    assign w_cnt_inc   = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
    // On a tie the source that was not served last wins.
    assign w_pick_arp  = tx.i_arp_tx_req & (~tx.i_udp_tx_req | ~r_last_arp);
    assign w_spurious  = (tx.i_arp_gmii_tx_en & ~r_grant_arp) | (tx.i_udp_gmii_tx_en & ~r_grant_udp);

    always_ff @(posedge i_gmii_tx_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_IDLE;
            r_cnt          <= 16'd0;
            r_grant_arp    <= 1'b0;
            r_grant_udp    <= 1'b0;
            r_last_arp     <= 1'b0;
            r_tx_en        <= 1'b0;
            r_tx_data      <= 8'h00;
            r_err_timeout  <= 1'b0;
            r_err_spurious <= 1'b0;
        end else begin
            r_tx_en        <= 1'b0;
            r_tx_data      <= 8'h00;
            r_err_timeout  <= 1'b0;
            r_err_spurious <= w_spurious;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= 16'd0;
                    if (w_pick_arp) begin
                        r_grant_arp <= 1'b1;
                        r_last_arp  <= 1'b1;
                        r_state     <= S_WAIT_START;
                    end else if (tx.i_udp_tx_req) begin
                        r_grant_udp <= 1'b1;
                        r_last_arp  <= 1'b0;
                        r_state     <= S_WAIT_START;
                    end
                end
                S_WAIT_START: begin
                    r_tx_en   <= w_lane_en;
                    r_tx_data <= w_lane_data;
                    if (w_lane_en) begin
                        // The first byte is already being forwarded, so the frame count starts at one.
                        r_cnt   <= 16'd1;
                        r_state <= S_SEND;
                    end else if (r_cnt >= LP_START_LAST) begin
                        r_grant_arp   <= 1'b0;
                        r_grant_udp   <= 1'b0;
                        r_err_timeout <= 1'b1;
                        r_cnt         <= 16'd0;
                        r_state       <= LP_AFTER_FRAME;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_SEND: begin
                    if (!w_lane_en) begin
                        r_grant_arp <= 1'b0;
                        r_grant_udp <= 1'b0;
                        r_cnt       <= 16'd0;
                        r_state     <= LP_AFTER_FRAME;
                    end else if (r_cnt >= LP_MAX_FRAME) begin
                        r_grant_arp   <= 1'b0;
                        r_grant_udp   <= 1'b0;
                        r_err_timeout <= 1'b1;
                        r_cnt         <= 16'd0;
                        r_state       <= LP_AFTER_FRAME;
                    end else begin
                        r_tx_en   <= 1'b1;
                        r_tx_data <= w_lane_data;
                        r_cnt     <= w_cnt_inc;
                    end
                end
                S_GAP: begin
                    if (r_cnt >= LP_GAP_LAST) begin
                        r_cnt   <= 16'd0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign tx.o_arp_tx_valid = r_grant_arp;
    assign tx.o_udp_tx_valid = r_grant_udp;
    assign tx.o_gmii_tx_en   = r_tx_en;
    assign tx.o_gmii_tx_data = r_tx_data;
    assign tx.o_err_timeout  = r_err_timeout;
    assign tx.o_err_spurious = r_err_spurious;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter: table of arbitration frames plus timeout, overrun,
// spurious-lane and mid-frame reset sequences.
module tb_eth_tx_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    eth_tx_arbiter_if bus ();

    eth_tx_arbiter #(
        .IFG_CYCLES   (12),
        .START_TIMEOUT(1024),
        .MAX_FRAME    (1600)
    ) dut (
        .i_gmii_tx_clk(clk),
        .i_rst_n      (rst_n),
        .tx           (bus)
    );

    typedef struct {
        string      name;
        bit         do_rst;
        bit         arp_req;
        bit         udp_req;
        bit         exp_arp;
        int         len;
        logic [7:0] base;
        int         exp_wait;
    } vec_t;

    vec_t vecs [9];

    int checks   = 0;
    int failures = 0;
    int idle_run = 0;
    int n_to = 0;
    int n_sp = 0;
    int n_aa = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_err_timeout) n_to++;
            if (bus.o_err_spurious) n_sp++;
            if (bus.o_gmii_tx_en && bus.o_gmii_tx_data == 8'hAA) n_aa++;
        end
    end

    function automatic vec_t mk(string n, bit r, bit a, bit u, bit ea, int len,
                                logic [7:0] base, int ew);
        vec_t v;
        v.name = n; v.do_rst = r; v.arp_req = a; v.udp_req = u;
        v.exp_arp = ea; v.len = len; v.base = base; v.exp_wait = ew;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (bus.o_gmii_tx_en) idle_run = 0;
        else idle_run++;
    endtask

    task automatic lanes(input logic ae, input logic [7:0] ad, input logic ue, input logic [7:0] ud);
        bus.i_arp_gmii_tx_en   = ae;
        bus.i_arp_gmii_tx_data = ad;
        bus.i_udp_gmii_tx_en   = ue;
        bus.i_udp_gmii_tx_data = ud;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.i_arp_tx_req = 1'b0;
        bus.i_udp_tx_req = 1'b0;
        lanes(1'b0, 8'h00, 1'b0, 8'h00);
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(output int n);
        n = 0;
        while (!(bus.o_arp_tx_valid || bus.o_udp_tx_valid) && n < 200) begin
            step();
            n++;
        end
    endtask

    // Called with the grant already visible; the engine starts its frame immediately.
    task automatic run_frame(input bit src_arp, input int len, input logic [7:0] base,
                             input int spur_at, input int spur_len, input string tag);
        logic [7:0] d;
        bit         sp;
        for (int i = 0; i < len; i++) begin
            d  = base + 8'(i);
            sp = (spur_at >= 0) && (i >= spur_at) && (i < spur_at + spur_len);
            if (src_arp) lanes(1'b1, d, sp, sp ? 8'hAA : 8'h00);
            else         lanes(sp, sp ? 8'hAA : 8'h00, 1'b1, d);
            step();
            chk({tag, "_en"}, int'(bus.o_gmii_tx_en), 1);
            chk({tag, "_dat"}, int'(bus.o_gmii_tx_data), int'(d));
        end
        chk({tag, "_grant_hold"}, int'(src_arp ? bus.o_arp_tx_valid : bus.o_udp_tx_valid), 1);
        lanes(1'b0, 8'h00, 1'b0, 8'h00);
        step();
        chk({tag, "_grant_drop"}, int'(src_arp ? bus.o_arp_tx_valid : bus.o_udp_tx_valid), 0);
        chk({tag, "_en_off"}, int'(bus.o_gmii_tx_en), 0);
    endtask

    initial begin
        int w;
        int n;
        int hi;
        int to0;
        int sp0;
        int aa0;

        vecs[0] = mk("arp_single",   1'b1, 1'b1, 1'b0, 1'b1, 64, 8'h00, 1);
        vecs[1] = mk("tie0_arp",     1'b1, 1'b1, 1'b1, 1'b1, 60, 8'h80, 1);
        vecs[2] = mk("tie1_udp",     1'b0, 1'b1, 1'b1, 1'b0, 60, 8'h10, 11);
        vecs[3] = mk("tie2_arp",     1'b0, 1'b1, 1'b1, 1'b1, 60, 8'h20, 11);
        vecs[4] = mk("tie3_udp",     1'b0, 1'b1, 1'b1, 1'b0, 60, 8'h30, 11);
        vecs[5] = mk("udp_only",     1'b0, 1'b0, 1'b1, 1'b0, 20, 8'h50, 11);
        vecs[6] = mk("tie_last_udp", 1'b0, 1'b1, 1'b1, 1'b1, 16, 8'h60, 11);
        vecs[7] = mk("arp_only",     1'b0, 1'b1, 1'b0, 1'b1,  8, 8'h70, 11);
        vecs[8] = mk("tie_last_arp", 1'b0, 1'b1, 1'b1, 1'b0,  8, 8'h90, 11);

        do_reset();
        chk("rst_arp_valid", int'(bus.o_arp_tx_valid), 0);
        chk("rst_udp_valid", int'(bus.o_udp_tx_valid), 0);
        chk("rst_tx_en",     int'(bus.o_gmii_tx_en), 0);
        chk("rst_tx_data",   int'(bus.o_gmii_tx_data), 0);
        chk("rst_err_to",    int'(bus.o_err_timeout), 0);
        chk("rst_err_sp",    int'(bus.o_err_spurious), 0);

        for (int k = 0; k < 9; k++) begin
            if (vecs[k].do_rst) do_reset();
            to0 = n_to;
            sp0 = n_sp;
            bus.i_arp_tx_req = vecs[k].arp_req;
            bus.i_udp_tx_req = vecs[k].udp_req;
            wait_grant(w);
            chk({vecs[k].name, "_wait"}, w, vecs[k].exp_wait);
            chk({vecs[k].name, "_arp_grant"}, int'(bus.o_arp_tx_valid), int'(vecs[k].exp_arp));
            chk({vecs[k].name, "_udp_grant"}, int'(bus.o_udp_tx_valid), int'(!vecs[k].exp_arp));
            if (!vecs[k].do_rst) chk({vecs[k].name, "_idle_gap"}, idle_run, 12);
            run_frame(vecs[k].exp_arp, vecs[k].len, vecs[k].base, -1, 0, vecs[k].name);
            chk({vecs[k].name, "_err_to"}, n_to - to0, 0);
            chk({vecs[k].name, "_err_sp"}, n_sp - sp0, 0);
        end
        bus.i_arp_tx_req = 1'b0;
        bus.i_udp_tx_req = 1'b0;

        // Start timeout: UDP never starts, ARP waits behind it.
        do_reset();
        to0 = n_to;
        bus.i_udp_tx_req = 1'b1;
        step();
        chk("to_udp_grant", int'(bus.o_udp_tx_valid), 1);
        bus.i_udp_tx_req = 1'b0;
        bus.i_arp_tx_req = 1'b1;
        n = 0;
        while (bus.o_udp_tx_valid && n < 2000) begin
            n++;
            step();
        end
        chk("to_grant_cycles", n, 1024);
        wait_grant(w);
        chk("to_arp_wait", w, 11);
        chk("to_arp_grant", int'(bus.o_arp_tx_valid), 1);
        bus.i_arp_tx_req = 1'b0;
        run_frame(1'b1, 8, 8'hC0, -1, 0, "to_arp");
        chk("to_pulses", n_to - to0, 1);

        // Overrun: ARP holds tx_en for 2000 cycles.
        to0 = n_to;
        bus.i_arp_tx_req = 1'b1;
        wait_grant(w);
        chk("ovr_arp_grant", int'(bus.o_arp_tx_valid), 1);
        bus.i_arp_tx_req = 1'b0;
        hi = 0;
        for (int i = 0; i < 2000; i++) begin
            lanes(1'b1, 8'(i), 1'b0, 8'h00);
            step();
            if (bus.o_gmii_tx_en) hi++;
        end
        lanes(1'b0, 8'h00, 1'b0, 8'h00);
        repeat (5) begin
            step();
            if (bus.o_gmii_tx_en) hi++;
        end
        chk("ovr_en_cycles", hi, 1600);
        chk("ovr_grant_drop", int'(bus.o_arp_tx_valid), 0);
        chk("ovr_pulses", n_to - to0, 1);
        bus.i_udp_tx_req = 1'b1;
        wait_grant(w);
        chk("ovr_udp_wait", w, 1);
        chk("ovr_udp_grant", int'(bus.o_udp_tx_valid), 1);
        bus.i_udp_tx_req = 1'b0;
        run_frame(1'b0, 10, 8'h05, -1, 0, "ovr_udp");
        chk("ovr_pulses_after", n_to - to0, 1);

        // Spurious UDP lane during an ARP frame.
        do_reset();
        sp0 = n_sp;
        aa0 = n_aa;
        to0 = n_to;
        bus.i_arp_tx_req = 1'b1;
        wait_grant(w);
        chk("sp_arp_grant", int'(bus.o_arp_tx_valid), 1);
        bus.i_arp_tx_req = 1'b0;
        run_frame(1'b1, 40, 8'h40, 10, 5, "sp_arp");
        step();
        chk("sp_pulses", n_sp - sp0, 5);
        chk("sp_aa_seen", n_aa - aa0, 0);
        chk("sp_err_to", n_to - to0, 0);

        // Asynchronous reset at byte 30 of a UDP frame.
        do_reset();
        bus.i_udp_tx_req = 1'b1;
        wait_grant(w);
        chk("mr_udp_grant", int'(bus.o_udp_tx_valid), 1);
        bus.i_udp_tx_req = 1'b0;
        for (int i = 0; i < 30; i++) begin
            lanes(1'b0, 8'h00, 1'b1, 8'(i + 1));
            step();
        end
        chk("mr_pre_en", int'(bus.o_gmii_tx_en), 1);
        lanes(1'b0, 8'h00, 1'b1, 8'd31);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_en",        int'(bus.o_gmii_tx_en), 0);
        chk("mr_data",      int'(bus.o_gmii_tx_data), 0);
        chk("mr_udp_valid", int'(bus.o_udp_tx_valid), 0);
        chk("mr_arp_valid", int'(bus.o_arp_tx_valid), 0);
        chk("mr_err_to",    int'(bus.o_err_timeout), 0);
        lanes(1'b0, 8'h00, 1'b0, 8'h00);
        step();
        step();
        rst_n = 1'b1;
        bus.i_arp_tx_req = 1'b1;
        bus.i_udp_tx_req = 1'b1;
        step();
        chk("mr_first_arp", int'(bus.o_arp_tx_valid), 1);
        chk("mr_first_udp", int'(bus.o_udp_tx_valid), 0);
        bus.i_arp_tx_req = 1'b0;
        bus.i_udp_tx_req = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
